// File: rtl/sram_2147_ctl_pkg.sv
// Shared definitions for the 2147-style SRAM access sequencers: state encoding,
// default timing constants and the counter sizing helper.
package sram_2147_ctl_pkg;

    localparam int unsigned AddrW         = 12;
    localparam int unsigned DefaultAccCyc = 2;
    localparam int unsigned DefaultWeCyc  = 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSetup   = 3'd1,
        StRdWait  = 3'd2,
        StWrPulse = 3'd3,
        StHold    = 3'd4
    } state_t;

    // Bits needed to count down the longer of the two strobe phases.
    function automatic int unsigned cnt_width(input int unsigned acc_cyc,
                                              input int unsigned we_cyc);
        int unsigned longest;
        longest = (acc_cyc > we_cyc) ? acc_cyc : we_cyc;
        return (longest + 1 > 2) ? $clog2(longest + 1) : 1;
    endfunction

endpackage

// File: rtl/sram_2147_ctl.sv
// Clocked request sequencer generating address, chip-enable and write-enable strobes
// for a bank of 4K x 1 static RAMs, with registered read-data capture.
module sram_2147_ctl
    import sram_2147_ctl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ACC_CYC = DefaultAccCyc,
    parameter int unsigned WE_CYC  = DefaultWeCyc
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [AddrW-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [AddrW-1:0]  ram_a,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    localparam int unsigned CntW = cnt_width(ACC_CYC, WE_CYC);
    localparam logic [CntW-1:0] AccLoad = CntW'(ACC_CYC - 1);
    localparam logic [CntW-1:0] WeLoad  = CntW'(WE_CYC - 1);

    if (ACC_CYC == 0 || WE_CYC == 0) begin : g_bad_cfg
        $error("sram_2147_ctl: ACC_CYC and WE_CYC must both be at least 1");
    end

    state_t          state;
    logic [CntW-1:0] cnt;
    logic            op_wr;

    // Every output is a register updated alongside the state, so the RAM pins
    // never see a combinational path from the request side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            cnt      <= '0;
            op_wr    <= 1'b0;
            ready    <= 1'b1;
            rvalid   <= 1'b0;
            rdata    <= '0;
            ram_a    <= '0;
            ram_ce_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_di   <= '0;
        end else begin
            rvalid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req) begin
                        ram_a    <= addr;
                        ram_di   <= wdata;
                        op_wr    <= we;
                        ready    <= 1'b0;
                        // Writes enable the part during setup; reads give the
                        // address a full cycle before ce_n falls.
                        ram_ce_n <= ~we;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    ram_ce_n <= 1'b0;
                    if (op_wr) begin
                        ram_we_n <= 1'b0;
                        cnt      <= WeLoad;
                        state    <= StWrPulse;
                    end else begin
                        cnt      <= AccLoad;
                        state    <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (cnt == '0) begin
                        rdata    <= ram_do;
                        rvalid   <= 1'b1;
                        ram_ce_n <= 1'b1;
                        state    <= StHold;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StWrPulse: begin
                    if (cnt == '0) begin
                        // ce_n stays low one more cycle so data and address
                        // are held past the rising edge of we_n.
                        ram_we_n <= 1'b1;
                        state    <= StHold;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StHold: begin
                    ram_ce_n <= 1'b1;
                    ready    <= 1'b1;
                    state    <= StIdle;
                end
                default: begin
                    ram_ce_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    ready    <= 1'b1;
                    state    <= StIdle;
                end
            endcase
        end
    end

    // Strobe-ordering properties of the RAM interface.
    a_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (!ram_ce_n && $past(!ram_ce_n)) |-> $stable(ram_a));
    a_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (!ram_ce_n && $past(!ram_ce_n)) |-> $stable(ram_di));
    a_we_inside_ce: assert property (@(posedge clk) disable iff (!reset_n)
        !ram_we_n |-> !ram_ce_n);
    a_we_not_with_ce: assert property (@(posedge clk) disable iff (!reset_n)
        $fell(ram_we_n) |-> !$fell(ram_ce_n));
    a_rvalid_pulse: assert property (@(posedge clk) disable iff (!reset_n)
        rvalid |=> !rvalid);
    a_ready_idle: assert property (@(posedge clk) disable iff (!reset_n)
        ready |-> (state == StIdle));

endmodule

// File: tb/tb_sram_2147_ctl.sv
// Randomised bench for sram_2147_ctl: two instances (default timing and ACC_CYC=4/WE_CYC=1)
// each driving a behavioural 4K x DATA_W RAM, checked against an array reference model.
module tb_sram_2147_ctl;

    localparam int unsigned DW    = 32;
    localparam int unsigned ACC_A = 2;
    localparam int unsigned WE_A  = 2;
    localparam int unsigned ACC_B = 4;
    localparam int unsigned WE_B  = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic          sel = 1'b0;
    logic [11:0]   addr = '0;
    logic [DW-1:0] wdata = '0;

    logic          ready_a, rvalid_a, ram_ce_n_a, ram_we_n_a;
    logic [DW-1:0] rdata_a, ram_di_a, ram_do_a;
    logic [11:0]   ram_a_a;
    logic          ready_b, rvalid_b, ram_ce_n_b, ram_we_n_b;
    logic [DW-1:0] rdata_b, ram_di_b, ram_do_b;
    logic [11:0]   ram_a_b;

    logic          m_ready, m_rvalid, m_ce_n, m_we_n;
    logic [DW-1:0] m_rdata, m_ram_di;
    logic [11:0]   m_ram_a;

    logic [DW-1:0] mem_a [4096];
    logic [DW-1:0] mem_b [4096];
    logic [DW-1:0] ref_mem [2][4096];
    logic [DW-1:0] last_read [2];
    logic [11:0]   pool [8];

    int n_vec = 0;
    int n_err = 0;
    int reads_acc = 0;
    int rv_seen = 0;

    always #5 clk = ~clk;

    sram_2147_ctl #(.DATA_W(DW), .ACC_CYC(ACC_A), .WE_CYC(WE_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .req(req & ~sel), .ready(ready_a), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata_a), .rvalid(rvalid_a), .ram_a(ram_a_a),
        .ram_ce_n(ram_ce_n_a), .ram_we_n(ram_we_n_a), .ram_di(ram_di_a), .ram_do(ram_do_a)
    );

    sram_2147_ctl #(.DATA_W(DW), .ACC_CYC(ACC_B), .WE_CYC(WE_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .req(req & sel), .ready(ready_b), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata_b), .rvalid(rvalid_b), .ram_a(ram_a_b),
        .ram_ce_n(ram_ce_n_b), .ram_we_n(ram_we_n_b), .ram_di(ram_di_b), .ram_do(ram_do_b)
    );

    // Behavioural RAM parts: write latched on the rising edge of we_n while selected.
    always @(posedge ram_we_n_a) if (!ram_ce_n_a) mem_a[ram_a_a] = ram_di_a;
    always @(posedge ram_we_n_b) if (!ram_ce_n_b) mem_b[ram_a_b] = ram_di_b;
    assign ram_do_a = ram_ce_n_a ? '0 : mem_a[ram_a_a];
    assign ram_do_b = ram_ce_n_b ? '0 : mem_b[ram_a_b];

    assign m_ready  = sel ? ready_b    : ready_a;
    assign m_rvalid = sel ? rvalid_b   : rvalid_a;
    assign m_ce_n   = sel ? ram_ce_n_b : ram_ce_n_a;
    assign m_we_n   = sel ? ram_we_n_b : ram_we_n_a;
    assign m_rdata  = sel ? rdata_b    : rdata_a;
    assign m_ram_di = sel ? ram_di_b   : ram_di_a;
    assign m_ram_a  = sel ? ram_a_b    : ram_a_a;

    always @(negedge clk) if (reset_n) rv_seen += int'(rvalid_a) + int'(rvalid_b);

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction on the selected instance, starting and ending on a falling edge.
    task automatic do_op(input logic w, input logic [11:0] a, input logic [DW-1:0] d,
                         input bit keep, input bit pulse);
        int acc, wec, busy, n, done_k, rv_k, rv_n, we_low, ce_low;
        logic [DW-1:0] exp_rd;
        acc  = sel ? ACC_B : ACC_A;
        wec  = sel ? WE_B : WE_A;
        busy = w ? wec + 2 : acc + 2;
        req = 1'b1; we = w; addr = a; wdata = d;
        n = 0;
        while (!m_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) check_eq("accept_timeout", DW'(m_ready), DW'(1));
        @(posedge clk);
        exp_rd = ref_mem[sel][a];
        if (w) ref_mem[sel][a] = d;
        else reads_acc++;
        @(negedge clk);
        if (!keep) req = 1'b0;
        check_eq("busy_after_accept", DW'(m_ready), DW'(0));
        ce_low = int'(!m_ce_n);
        we_low = int'(!m_we_n);
        done_k = 0; rv_k = 0; rv_n = 0;
        for (int k = 1; k <= busy + 4 && done_k == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!m_ce_n) begin
                ce_low++;
                check_eq("addr_hold", DW'(m_ram_a), DW'(a));
                if (w) check_eq("di_hold", m_ram_di, d);
            end
            if (!m_we_n) we_low++;
            if (m_rvalid) begin
                rv_n++;
                if (rv_k == 0) rv_k = k;
                check_eq("rdata", m_rdata, exp_rd);
            end
            if (m_ready) done_k = k;
            if (pulse && k == 1) begin
                req = 1'b1; we = ~w; addr = ~a; wdata = ~d;
            end
            if (pulse && k == 2) req = 1'b0;
        end
        if (pulse) req = 1'b0;
        check_eq("busy_cycles", DW'(done_k), DW'(busy));
        check_eq("we_low_cycles", DW'(we_low), DW'(w ? wec : 0));
        check_eq("ce_low_cycles", DW'(ce_low), DW'(w ? wec + 2 : acc));
        check_eq("rvalid_count", DW'(rv_n), DW'(w ? 0 : 1));
        if (!w) begin
            check_eq("rvalid_latency", DW'(rv_k), DW'(acc + 1));
            last_read[sel] = exp_rd;
        end
        check_eq("rdata_hold", m_rdata, last_read[sel]);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0; mem_b[i] = '0;
            ref_mem[0][i] = '0; ref_mem[1][i] = '0;
        end
        last_read[0] = '0; last_read[1] = '0;
        pool[0] = 12'h000; pool[1] = 12'hFFF; pool[2] = 12'h123; pool[3] = 12'h321;
        pool[4] = 12'h0A5; pool[5] = 12'h5A0; pool[6] = 12'h7FF; pool[7] = 12'h800;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", DW'(ready_a), DW'(1));
        check_eq("rst_ce_n", DW'(ram_ce_n_a), DW'(1));
        check_eq("rst_we_n", DW'(ram_we_n_a), DW'(1));
        check_eq("rst_rvalid", DW'(rvalid_a), DW'(0));
        check_eq("rst_rdata", rdata_a, '0);
        check_eq("rst_ram_a", DW'(ram_a_a), '0);
        check_eq("rst_ram_di", ram_di_a, '0);
        check_eq("rst_ready_b", DW'(ready_b), DW'(1));
        reset_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        do_op(1'b1, 12'h123, 32'hDEADBEEF, 1'b0, 1'b0);
        do_op(1'b0, 12'h123, 32'h0, 1'b0, 1'b0);
        check_eq("read_123", m_rdata, 32'hDEADBEEF);

        sel = 1'b1;
        do_op(1'b1, 12'h321, 32'h0BADF00D, 1'b0, 1'b1);
        do_op(1'b0, 12'h321, 32'h0, 1'b0, 1'b1);
        check_eq("read_321_b", m_rdata, 32'h0BADF00D);

        sel = 1'b0;
        do_op(1'b1, 12'h000, 32'h1, 1'b1, 1'b0);
        do_op(1'b1, 12'hFFF, 32'h2, 1'b1, 1'b0);
        do_op(1'b0, 12'hFFF, 32'h0, 1'b1, 1'b0);
        check_eq("b2b_read_fff", m_rdata, 32'h2);
        do_op(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        check_eq("b2b_read_000", m_rdata, 32'h1);

        for (int i = 0; i < 60; i++) begin
            bit kp;
            sel = 1'($urandom_range(0, 1));
            kp = ($urandom_range(0, 3) == 0) && (i != 59);
            do_op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
                  kp, !kp && ($urandom_range(0, 2) == 0));
        end

        // Abort a write to an address that is never read again.
        sel = 1'b0;
        req = 1'b1; we = 1'b1; addr = 12'h456; wdata = 32'hA5A5A5A5;
        begin
            int n = 0;
            while (!m_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!m_ready) check_eq("abort_accept_timeout", DW'(m_ready), DW'(1));
        end
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_in_pulse", DW'(m_we_n), DW'(0));
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort_ready", DW'(m_ready), DW'(1));
        check_eq("abort_ce_n", DW'(m_ce_n), DW'(1));
        check_eq("abort_we_n", DW'(m_we_n), DW'(1));
        check_eq("abort_rvalid", DW'(m_rvalid), DW'(0));
        check_eq("abort_rdata", m_rdata, '0);
        last_read[0] = '0; last_read[1] = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_ready", DW'(m_ready), DW'(1));
        do_op(1'b0, 12'h123, 32'h0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("rvalid_total", DW'(rv_seen), DW'(reads_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
